timer_sched: RTL and testbench

TIMER_SCHED -- requirements
Module: timer_sched

---
 rtl/timer_sched_if.sv | 29 ++
 rtl/timer_sched.sv | 201 ++++++++++++++++++++
 tb/tb_timer_sched.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/timer_sched_if.sv
// ----------------------------------------------------------------------------
// timer_sched_if -- register bus between a CPU-side master and timer_sched.
//
// Signals:
//   address_in      32  bus address (the timer decodes bits [3:2] only)
//   sel_in           1  block selected for this bus cycle
//   read_in          1  read strobe (informational; decode ignores it)
//   write_mask_in    4  byte write enables, bit n covers [8n+7:8n]
//   write_value_in  32  write data
//   read_value_out  32  combinational read data from the timer
// ----------------------------------------------------------------------------
interface timer_sched_if;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic [31:0] read_value_out;

  modport master (
    output address_in, sel_in, read_in, write_mask_in, write_value_in,
    input  read_value_out
  );

  modport slave (
    input  address_in, sel_in, read_in, write_mask_in, write_value_in,
    output read_value_out
  );
endinterface

// File: rtl/timer_sched.sv
// ----------------------------------------------------------------------------
// timer_sched -- 64-bit deadline timer with one-shot and periodic modes.
//
// A deadline is compared against the CPU cycle counter through a two-stage
// pipeline; a hit raises CTRL.pending (irq_out). In periodic mode the FSM
// reloads DEADLINE += PERIOD in two halves (low word with carry, then high
// word) and re-arms. A hit while pending is still set flags overrun.
//
// Ports:
//   clk       sole clock, rising edge
//   reset     asynchronous active-high reset
//   cycle_in  64-bit free-running cycle count
//   bus       register bus (slave side), registers at [3:2]:
//               00 CTRL  {overrun, pending, periodic, enable}
//               01 PERIOD
//               10 DEADLINE[31:0]
//               11 DEADLINE[63:32]
//   irq_out   interrupt request, mirrors CTRL.pending
// ----------------------------------------------------------------------------
module timer_sched (
  input  logic          clk,
  input  logic          reset,
  input  logic [63:0]   cycle_in,
  timer_sched_if.slave  bus,
  output logic          irq_out
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARMED     = 2'd1,
    S_RELOAD_LO = 2'd2,
    S_RELOAD_HI = 2'd3
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'b00;
  localparam logic [1:0] A_PERIOD = 2'b01;
  localparam logic [1:0] A_DL_LO  = 2'b10;
  localparam logic [1:0] A_DL_HI  = 2'b11;

  state_t      r_state;
  logic        r_enable;
  logic        r_periodic;
  logic        r_pending;
  logic        r_overrun;
  logic [31:0] r_period;
  logic [63:0] r_deadline;
  logic        r_carry;

  // compare pipeline stage 1
  logic        r_lo_ge;
  logic        r_hi_gt;
  logic        r_hi_eq;
  logic        r_valid1;

  logic [1:0]  w_addr;
  logic        w_wr;
  logic        w_ctrl_wr;
  logic        w_period_wr;
  logic        w_dl_lo_wr;
  logic        w_dl_hi_wr;
  logic        w_dl_wr;
  logic        w_ctrl_dis;
  logic        w_clr_pending;
  logic        w_clr_overrun;
  logic        w_hit;
  logic [31:0] w_period_bus;
  logic [31:0] w_dl_lo_bus;
  logic [31:0] w_dl_hi_bus;
  logic [32:0] w_reload_sum;
  logic [31:0] w_read_value;
  logic        w_unused;

  assign w_addr        = bus.address_in[3:2];
  assign w_wr          = bus.sel_in & (|bus.write_mask_in);
  assign w_ctrl_wr     = bus.sel_in & bus.write_mask_in[0] & (w_addr == A_CTRL);
  assign w_period_wr   = w_wr & (w_addr == A_PERIOD);
  assign w_dl_lo_wr    = w_wr & (w_addr == A_DL_LO);
  assign w_dl_hi_wr    = w_wr & (w_addr == A_DL_HI);
  assign w_dl_wr       = w_dl_lo_wr | w_dl_hi_wr;
  assign w_ctrl_dis    = w_ctrl_wr & ~bus.write_value_in[0];
  assign w_clr_pending = w_ctrl_wr & bus.write_value_in[2];
  assign w_clr_overrun = w_ctrl_wr & bus.write_value_in[3];

  // Stage 2: valid1 can only be high while ARMED, the state check is belt
  // and braces against a stale compare.
  assign w_hit = r_valid1 & (r_state == S_ARMED) & (r_hi_gt | (r_hi_eq & r_lo_ge));

  assign w_reload_sum = {1'b0, r_deadline[31:0]} + {1'b0, r_period};

  // Byte-lane merge of bus writes into PERIOD and both DEADLINE words.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_period_bus[8*gi +: 8] = (w_period_wr & bus.write_mask_in[gi]) ?
                                       bus.write_value_in[8*gi +: 8] : r_period[8*gi +: 8];
      assign w_dl_lo_bus[8*gi +: 8]  = (w_dl_lo_wr & bus.write_mask_in[gi]) ?
                                       bus.write_value_in[8*gi +: 8] : r_deadline[8*gi +: 8];
      assign w_dl_hi_bus[8*gi +: 8]  = (w_dl_hi_wr & bus.write_mask_in[gi]) ?
                                       bus.write_value_in[8*gi +: 8] : r_deadline[32 + 8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_enable   <= 1'b0;
      r_periodic <= 1'b0;
      r_pending  <= 1'b0;
      r_overrun  <= 1'b0;
      r_period   <= 32'h0;
      r_deadline <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_carry    <= 1'b0;
      r_lo_ge    <= 1'b0;
      r_hi_gt    <= 1'b0;
      r_hi_eq    <= 1'b0;
      r_valid1   <= 1'b0;
    end else begin
      r_lo_ge <= (cycle_in[31:0]  >= r_deadline[31:0]);
      r_hi_gt <= (cycle_in[63:32] >  r_deadline[63:32]);
      r_hi_eq <= (cycle_in[63:32] == r_deadline[63:32]);
      // Only a compare taken while staying ARMED against an untouched
      // deadline may qualify next cycle.
      r_valid1 <= (r_state == S_ARMED) & ~w_hit & ~w_dl_wr & ~w_ctrl_dis;

      // A hit beats a same-cycle clear; overrun only when pending was
      // genuinely left standing.
      if (w_hit) begin
        r_pending <= 1'b1;
        if (r_pending & ~w_clr_pending)
          r_overrun <= 1'b1;
        else if (w_clr_overrun)
          r_overrun <= 1'b0;
      end else begin
        if (w_clr_pending) r_pending <= 1'b0;
        if (w_clr_overrun) r_overrun <= 1'b0;
      end

      r_period   <= w_period_bus;
      r_deadline <= {w_dl_hi_bus, w_dl_lo_bus};

      case (r_state)
        S_IDLE: begin
          if (r_enable) r_state <= S_ARMED;
        end
        S_ARMED: begin
          if (w_hit) begin
            if (r_periodic) begin
              r_state <= S_RELOAD_LO;
            end else begin
              r_state  <= S_IDLE;
              r_enable <= 1'b0;
            end
          end
        end
        S_RELOAD_LO: begin
          if (w_dl_wr) begin
            // software rewrote the deadline: drop the reload entirely
            r_state <= r_enable ? S_ARMED : S_IDLE;
          end else begin
            r_deadline[31:0] <= w_reload_sum[31:0];
            r_carry          <= w_reload_sum[32];
            r_state          <= S_RELOAD_HI;
          end
        end
        S_RELOAD_HI: begin
          if (w_dl_wr) begin
            r_state <= r_enable ? S_ARMED : S_IDLE;
          end else begin
            r_deadline[63:32] <= r_deadline[63:32] + {31'b0, r_carry};
            r_state           <= S_ARMED;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Bus CTRL writes override the one-shot auto-disable.
      if (w_ctrl_wr) begin
        r_enable   <= bus.write_value_in[0];
        r_periodic <= bus.write_value_in[1];
      end
      if (w_ctrl_dis) r_state <= S_IDLE;
    end
  end

  always_comb begin
    w_read_value = 32'h0;
    case (w_addr)
      A_CTRL:   w_read_value = {28'h0, r_overrun, r_pending, r_periodic, r_enable};
      A_PERIOD: w_read_value = r_period;
      A_DL_LO:  w_read_value = r_deadline[31:0];
      A_DL_HI:  w_read_value = r_deadline[63:32];
      default:  w_read_value = 32'h0;
    endcase
  end

  assign bus.read_value_out = bus.sel_in ? w_read_value : 32'h0;
  assign irq_out            = r_pending;

  // read strobe and undecoded address bits are deliberately ignored
  assign w_unused = ^{bus.read_in, bus.address_in[31:4], bus.address_in[1:0]};

endmodule

// File: tb/tb_timer_sched.sv
// ----------------------------------------------------------------------------
// tb_timer_sched -- directed self-checking bench for timer_sched.
// Inputs change on the falling edge; outputs are checked away from the
// rising edge. One line is printed per bus transaction.
// ----------------------------------------------------------------------------
module tb_timer_sched;

  logic        clk;
  logic        reset;
  logic [63:0] cycle_in;
  logic        irq_out;
  int          total;
  int          bad;

  timer_sched_if bus ();

  timer_sched dut (
    .clk      (clk),
    .reset    (reset),
    .cycle_in (cycle_in),
    .bus      (bus),
    .irq_out  (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] A_CTRL   = 2'b00;
  localparam logic [1:0] A_PERIOD = 2'b01;
  localparam logic [1:0] A_DL_LO  = 2'b10;
  localparam logic [1:0] A_DL_HI  = 2'b11;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one bus write, landing on the next rising edge; returns on the next falling edge
  task automatic wr(input logic [1:0] a, input logic [3:0] m, input logic [31:0] d);
    $display("wr  addr=%0d mask=%b data=%h", a, m, d);
    bus.address_in     = {28'h0, a, 2'b00};
    bus.write_mask_in  = m;
    bus.write_value_in = d;
    bus.sel_in         = 1'b1;
    @(negedge clk);
    bus.sel_in         = 1'b0;
    bus.write_mask_in  = 4'h0;
  endtask

  // combinational read, no clock edge consumed
  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus.address_in    = {28'h0, a, 2'b00};
    bus.write_mask_in = 4'h0;
    bus.sel_in        = 1'b1;
    bus.read_in       = 1'b1;
    #1;
    v = bus.read_value_out;
    bus.sel_in  = 1'b0;
    bus.read_in = 1'b0;
    $display("rd  addr=%0d data=%h", a, v);
    chk(tag, {32'h0, v}, {32'h0, exp});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    cycle_in = 64'h0;
    bus.address_in = 32'h0;
    bus.sel_in = 1'b0;
    bus.read_in = 1'b0;
    bus.write_mask_in = 4'h0;
    bus.write_value_in = 32'h0;

    // reset state
    tick(2);
    chk("rst_irq", {63'h0, irq_out}, 64'h0);
    bus.address_in = 32'h4;
    #1 chk("rst_rd_unsel", {32'h0, bus.read_value_out}, 64'h0);
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_period", A_PERIOD, 32'h0);
    rd_chk("rst_dl_lo", A_DL_LO, 32'hFFFF_FFFF);
    rd_chk("rst_dl_hi", A_DL_HI, 32'hFFFF_FFFF);
    @(negedge clk);
    reset = 1'b0;
    tick(1);

    // byte-masked PERIOD write, unselected read
    wr(A_PERIOD, 4'b0101, 32'hAABB_CCDD);
    rd_chk("period_mask", A_PERIOD, 32'h00BB_00DD);
    bus.address_in = 32'h4;
    bus.sel_in = 1'b0;
    #1 chk("unsel_read", {32'h0, bus.read_value_out}, 64'h0);

    // one-shot at deadline 100
    wr(A_DL_LO, 4'hF, 32'd100);
    wr(A_DL_HI, 4'hF, 32'd0);
    wr(A_CTRL, 4'h1, 32'h1);
    tick(3);
    cycle_in = 64'd98;  tick(1);
    cycle_in = 64'd99;  tick(1);
    cycle_in = 64'd100; tick(1);
    chk("oneshot_irq_early", {63'h0, irq_out}, 64'h0);
    cycle_in = 64'd101; tick(1);
    chk("oneshot_irq", {63'h0, irq_out}, 64'h1);
    rd_chk("oneshot_ctrl", A_CTRL, 32'h4);
    tick(3);
    chk("oneshot_no_refire", {63'h0, irq_out}, 64'h1);
    wr(A_CTRL, 4'h1, 32'h4);
    rd_chk("oneshot_clr", A_CTRL, 32'h0);

    // periodic reload with carry out of the low word
    cycle_in = 64'h0;
    wr(A_DL_LO, 4'hF, 32'hFFFF_FFF0);
    wr(A_DL_HI, 4'hF, 32'h0);
    wr(A_PERIOD, 4'hF, 32'h20);
    wr(A_CTRL, 4'h1, 32'h3);
    tick(3);
    cycle_in = 64'h0000_0000_FFFF_FFF0;
    tick(2);
    chk("carry_irq", {63'h0, irq_out}, 64'h1);
    tick(1);
    rd_chk("carry_mid_lo", A_DL_LO, 32'h10);
    rd_chk("carry_mid_hi", A_DL_HI, 32'h0);
    tick(1);
    rd_chk("carry_lo", A_DL_LO, 32'h10);
    rd_chk("carry_hi", A_DL_HI, 32'h1);

    // second hit with pending left set -> overrun
    cycle_in = 64'h0000_0001_0000_0010;
    tick(2);
    rd_chk("overrun_ctrl", A_CTRL, 32'hF);
    tick(3);
    rd_chk("reload2_lo", A_DL_LO, 32'h30);
    wr(A_CTRL, 4'h1, 32'hF);
    rd_chk("clr_ctrl", A_CTRL, 32'h3);
    chk("clr_irq", {63'h0, irq_out}, 64'h0);

    // PERIOD=0: re-fire every 4 cycles, clear colliding with a hit
    wr(A_PERIOD, 4'hF, 32'h0);
    cycle_in = 64'h0000_0001_0000_0030;
    tick(2);
    chk("p0_hit1", {63'h0, irq_out}, 64'h1);
    wr(A_CTRL, 4'h1, 32'h7);
    rd_chk("p0_cleared", A_CTRL, 32'h3);
    tick(3);
    rd_chk("p0_hit2", A_CTRL, 32'h7);
    tick(3);
    wr(A_CTRL, 4'h1, 32'h7);
    rd_chk("p0_set_wins", A_CTRL, 32'h7);
    tick(4);
    rd_chk("p0_overrun", A_CTRL, 32'hF);
    wr(A_CTRL, 4'h1, 32'hC);
    chk("disable_irq", {63'h0, irq_out}, 64'h0);

    // DEADLINE_H write during RELOAD_LO aborts the reload
    cycle_in = 64'h0;
    wr(A_DL_LO, 4'hF, 32'h100);
    wr(A_DL_HI, 4'hF, 32'h0);
    wr(A_PERIOD, 4'hF, 32'h50);
    wr(A_CTRL, 4'h1, 32'h3);
    tick(3);
    cycle_in = 64'h100;
    tick(2);
    chk("abort_hit", {63'h0, irq_out}, 64'h1);
    wr(A_DL_HI, 4'hF, 32'hFFFF_FFFF);
    rd_chk("abort_lo", A_DL_LO, 32'h100);
    rd_chk("abort_hi", A_DL_HI, 32'hFFFF_FFFF);
    wr(A_CTRL, 4'h1, 32'h7);
    tick(6);
    chk("abort_no_hit", {63'h0, irq_out}, 64'h0);
    rd_chk("abort_lo_later", A_DL_LO, 32'h100);
    rd_chk("abort_ctrl", A_CTRL, 32'h3);

    // async reset mid-cycle with irq high and a reload in flight
    wr(A_DL_HI, 4'hF, 32'h0);
    tick(2);
    chk("pre_reset_irq", {63'h0, irq_out}, 64'h1);
    #2 reset = 1'b1;
    #1 chk("async_irq", {63'h0, irq_out}, 64'h0);
    bus.address_in = 32'h0;
    bus.sel_in = 1'b0;
    chk("async_rd_unsel", {32'h0, bus.read_value_out}, 64'h0);
    rd_chk("async_ctrl", A_CTRL, 32'h0);
    rd_chk("async_period", A_PERIOD, 32'h0);
    rd_chk("async_dl_lo", A_DL_LO, 32'hFFFF_FFFF);
    rd_chk("async_dl_hi", A_DL_HI, 32'hFFFF_FFFF);
    @(negedge clk);
    reset = 1'b0;

    // no hit without a fresh enable, then a one-shot at the max deadline
    cycle_in = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(4);
    chk("post_reset_quiet", {63'h0, irq_out}, 64'h0);
    wr(A_CTRL, 4'h1, 32'h1);
    tick(4);
    chk("post_reset_hit", {63'h0, irq_out}, 64'h1);
    rd_chk("post_reset_ctrl", A_CTRL, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
